// File: rtl/id_stage_ctrl_pkg.sv
// id_stage_ctrl_pkg: shared definitions for the ID stage sequencer.
//   - FSM state encoding (EMPTY / FULL / HOLD)
//   - immediate-format select codes driven on id_imm_sel_o
//   - RV32I major opcode values (instr[6:2]) and a legality helper
package id_stage_ctrl_pkg;

  localparam int XLEN_DEF = 32;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_HOLD  = 2'd2
  } id_state_e;

  localparam logic [2:0] IMM_SEL_I    = 3'd0;
  localparam logic [2:0] IMM_SEL_S    = 3'd1;
  localparam logic [2:0] IMM_SEL_B    = 3'd2;
  localparam logic [2:0] IMM_SEL_U    = 3'd3;
  localparam logic [2:0] IMM_SEL_J    = 3'd4;
  localparam logic [2:0] IMM_SEL_NONE = 3'd5;

  localparam logic [4:0] OP_LOAD     = 5'b00000;
  localparam logic [4:0] OP_MISC_MEM = 5'b00011;
  localparam logic [4:0] OP_IMM      = 5'b00100;
  localparam logic [4:0] OP_AUIPC    = 5'b00101;
  localparam logic [4:0] OP_STORE    = 5'b01000;
  localparam logic [4:0] OP_OP       = 5'b01100;
  localparam logic [4:0] OP_LUI      = 5'b01101;
  localparam logic [4:0] OP_BRANCH   = 5'b11000;
  localparam logic [4:0] OP_JALR     = 5'b11001;
  localparam logic [4:0] OP_JAL      = 5'b11011;
  localparam logic [4:0] OP_SYSTEM   = 5'b11100;

  function automatic logic is_rv32i_major(input logic [4:0] op);
    return op inside {OP_LOAD, OP_MISC_MEM, OP_IMM, OP_AUIPC, OP_STORE, OP_OP,
                      OP_LUI, OP_BRANCH, OP_JALR, OP_JAL, OP_SYSTEM};
  endfunction

endpackage

// File: rtl/id_stage_ctrl_imm_fmt_decode.sv
// id_stage_ctrl_imm_fmt_decode: combinational opcode pre-decode, shared with
// the main decoder.
//   opcode_i    : instr[6:0]
//   imm_sel_o   : immediate format (IMM_SEL_*)
//   rs1_used_o  : instruction reads rs1 (R, I, S, B formats)
//   rs2_used_o  : instruction reads rs2 (R, S, B formats)
//   illegal_o   : low bits not 2'b11, or not an RV32I major opcode
module id_stage_ctrl_imm_fmt_decode
  import id_stage_ctrl_pkg::*;
(
  input  logic [6:0] opcode_i,
  output logic [2:0] imm_sel_o,
  output logic       rs1_used_o,
  output logic       rs2_used_o,
  output logic       illegal_o
);

  // Anything not explicitly S/B/U/J/R falls back to the I format, including
  // illegal opcodes; the illegal flag carries that information separately.
  always_comb begin
    imm_sel_o = IMM_SEL_I;
    case (opcode_i[6:2])
      OP_STORE:         imm_sel_o = IMM_SEL_S;
      OP_BRANCH:        imm_sel_o = IMM_SEL_B;
      OP_LUI, OP_AUIPC: imm_sel_o = IMM_SEL_U;
      OP_JAL:           imm_sel_o = IMM_SEL_J;
      OP_OP:            imm_sel_o = IMM_SEL_NONE;
      default:          imm_sel_o = IMM_SEL_I;
    endcase
  end

  // NONE is the R format here, so it reads both sources.
  assign rs1_used_o = (imm_sel_o != IMM_SEL_U) && (imm_sel_o != IMM_SEL_J);
  assign rs2_used_o = (imm_sel_o == IMM_SEL_S) || (imm_sel_o == IMM_SEL_B) ||
                      (imm_sel_o == IMM_SEL_NONE);
  assign illegal_o  = (opcode_i[1:0] != 2'b11) || !is_rv32i_major(opcode_i[6:2]);

endmodule

// File: rtl/id_stage_ctrl.sv
// id_stage_ctrl: ID-stage sequencer. Owns the IF/ID register, both valid/ready
// handshakes, the load-use bubble and redirect flush.
//   clk_i, rst_ni        : clock, synchronous active-low reset
//   if_valid_i/if_instr_i/if_pc_i, if_ready_o  : IF side handshake
//   id_valid_o, id_instr_o, id_pc_o, id_imm_sel_o, id_illegal_o, ex_ready_i
//                        : EX side handshake and registered instruction
//   ex_valid_i, ex_load_i, ex_rd_i : EX occupant info for load-use detection
//   redirect_i           : taken branch/jump in EX, flushes ID
//   stall_cnt_o, flush_cnt_o : saturating perf counters (ID_PERF_CNT_EN only)
// Optional feature macro: ID_PERF_CNT_EN.
module id_stage_ctrl
  import id_stage_ctrl_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
`ifdef ID_PERF_CNT_EN
  , parameter int CNT_WIDTH = 32
`endif
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            if_valid_i,
  input  logic [XLEN-1:0] if_instr_i,
  input  logic [XLEN-1:0] if_pc_i,
  output logic            if_ready_o,
  output logic            id_valid_o,
  output logic [XLEN-1:0] id_instr_o,
  output logic [XLEN-1:0] id_pc_o,
  output logic [2:0]      id_imm_sel_o,
  output logic            id_illegal_o,
  input  logic            ex_ready_i,
  input  logic            ex_valid_i,
  input  logic            ex_load_i,
  input  logic [4:0]      ex_rd_i,
  input  logic            redirect_i
`ifdef ID_PERF_CNT_EN
  , output logic [CNT_WIDTH-1:0] stall_cnt_o,
  output logic [CNT_WIDTH-1:0] flush_cnt_o
`endif
);

  id_state_e state_q;
  logic      rs1_used_q, rs2_used_q;
  logic [2:0] dec_sel;
  logic      dec_rs1, dec_rs2, dec_ill;
  logic      hazard, xfer_out, capture;

  id_stage_ctrl_imm_fmt_decode u_dec (
    .opcode_i   (if_instr_i[6:0]),
    .imm_sel_o  (dec_sel),
    .rs1_used_o (dec_rs1),
    .rs2_used_o (dec_rs2),
    .illegal_o  (dec_ill)
  );

  // Only FULL checks; HOLD means the bubble was already paid.
  assign hazard = (state_q == ST_FULL) && ex_valid_i && ex_load_i && (ex_rd_i != 5'd0) &&
                  ((rs1_used_q && (ex_rd_i == id_instr_o[19:15])) ||
                   (rs2_used_q && (ex_rd_i == id_instr_o[24:20])));

  assign id_valid_o = ((state_q == ST_FULL && !hazard) || state_q == ST_HOLD) && !redirect_i;
  assign xfer_out   = id_valid_o && ex_ready_i;
  // Under redirect the IF beat is accepted and dropped.
  assign if_ready_o = (state_q == ST_EMPTY) || xfer_out || redirect_i;
  assign capture    = if_valid_i && if_ready_o;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= ST_EMPTY;
      id_instr_o   <= '0;
      id_pc_o      <= '0;
      id_imm_sel_o <= IMM_SEL_NONE;
      id_illegal_o <= 1'b0;
      rs1_used_q   <= 1'b0;
      rs2_used_q   <= 1'b0;
    end else if (redirect_i) begin
      state_q <= ST_EMPTY;
    end else if (hazard) begin
      state_q <= ST_HOLD;
    end else if (state_q == ST_HOLD && !ex_ready_i) begin
      state_q <= ST_HOLD;
    end else if (capture) begin
      state_q      <= ST_FULL;
      id_instr_o   <= if_instr_i;
      id_pc_o      <= if_pc_i;
      id_imm_sel_o <= dec_sel;
      id_illegal_o <= dec_ill;
      rs1_used_q   <= dec_rs1;
      rs2_used_q   <= dec_rs2;
    end else if (xfer_out) begin
      state_q <= ST_EMPTY;
    end
  end

`ifdef ID_PERF_CNT_EN
  logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  logic [CNT_WIDTH:0]   stall_sum, flush_sum;
  logic [1:0]           flush_inc;

  // A flush of a held instruction counts 1, plus 1 for a same-cycle IF beat.
  assign flush_inc = (redirect_i && state_q != ST_EMPTY) ? (if_valid_i ? 2'd2 : 2'd1) : 2'd0;
  // Extra top bit catches overflow so the counters stick at all-ones.
  assign stall_sum   = {1'b0, stall_cnt_q} + (CNT_WIDTH+1)'(hazard && !redirect_i);
  assign flush_sum   = {1'b0, flush_cnt_q} + (CNT_WIDTH+1)'(flush_inc);
  assign stall_cnt_d = stall_sum[CNT_WIDTH] ? '1 : stall_sum[CNT_WIDTH-1:0];
  assign flush_cnt_d = flush_sum[CNT_WIDTH] ? '1 : flush_sum[CNT_WIDTH-1:0];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`endif

endmodule

// File: tb/tb_id_stage_ctrl.sv
module tb_id_stage_ctrl;

  logic        clk = 1'b0;
  logic        rstn;
  logic        iv, er, ev, el, rdr;
  logic [31:0] ins, pc;
  logic [4:0]  rd;
  logic        if_ready_o, id_valid_o, id_illegal_o;
  logic [31:0] id_instr_o, id_pc_o;
  logic [2:0]  id_imm_sel_o;
`ifdef ID_PERF_CNT_EN
  logic [31:0] stall_cnt_o, flush_cnt_o;
`endif

  always #5 clk = ~clk;

  id_stage_ctrl dut (
    .clk_i(clk), .rst_ni(rstn),
    .if_valid_i(iv), .if_instr_i(ins), .if_pc_i(pc), .if_ready_o(if_ready_o),
    .id_valid_o(id_valid_o), .id_instr_o(id_instr_o), .id_pc_o(id_pc_o),
    .id_imm_sel_o(id_imm_sel_o), .id_illegal_o(id_illegal_o),
    .ex_ready_i(er), .ex_valid_i(ev), .ex_load_i(el), .ex_rd_i(rd),
    .redirect_i(rdr)
`ifdef ID_PERF_CNT_EN
    , .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h @%0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // ID holds at most one instruction; 'bub' records that its bubble was paid.
  logic        m_held, m_bub, m_ill;
  logic [31:0] m_instr, m_pc;
  logic [2:0]  m_sel;
  int          m_stall, m_flush;

  function automatic logic [2:0] ref_sel(input logic [31:0] i);
    case (i[6:2])
      5'b01000:          return 3'd1;  // STORE  -> S
      5'b11000:          return 3'd2;  // BRANCH -> B
      5'b01101, 5'b00101: return 3'd3; // LUI/AUIPC -> U
      5'b11011:          return 3'd4;  // JAL    -> J
      5'b01100:          return 3'd5;  // OP     -> NONE (R)
      default:           return 3'd0;
    endcase
  endfunction

  function automatic logic ref_ill(input logic [31:0] i);
    logic [4:0] legal [11] = '{5'b00000, 5'b00011, 5'b00100, 5'b00101, 5'b01000, 5'b01100,
                               5'b01101, 5'b11000, 5'b11001, 5'b11011, 5'b11100};
    logic found = 1'b0;
    foreach (legal[k]) if (legal[k] == i[6:2]) found = 1'b1;
    return (i[1:0] != 2'b11) || !found;
  endfunction

  task automatic drive(input logic iv_, input logic [31:0] ins_, input logic er_,
                       input logic ev_, input logic el_, input logic [4:0] rd_, input logic rdr_);
    iv = iv_; ins = ins_; er = er_; ev = ev_; el = el_; rd = rd_; rdr = rdr_;
    pc = pc + 32'd4;
    #1;
  endtask

  // Compare this cycle against the model, advance the model, then clock.
  task automatic check_and_tick();
    logic [2:0] fmt;
    logic u1, u2, haz, e_vld, e_rdy;
    fmt   = ref_sel(m_instr);
    u1    = (fmt != 3'd3) && (fmt != 3'd4);
    u2    = (fmt == 3'd1) || (fmt == 3'd2) || (fmt == 3'd5);
    haz   = m_held && !m_bub && ev && el && (rd != 5'd0) &&
            ((u1 && rd == m_instr[19:15]) || (u2 && rd == m_instr[24:20]));
    e_vld = m_held && !haz && !rdr;
    e_rdy = !m_held || (e_vld && er) || rdr;
    chk("id_valid", 32'(id_valid_o), 32'(e_vld));
    chk("if_ready", 32'(if_ready_o), 32'(e_rdy));
    chk("id_instr", id_instr_o, m_instr);
    chk("id_pc", id_pc_o, m_pc);
    chk("id_imm_sel", 32'(id_imm_sel_o), 32'(m_sel));
    chk("id_illegal", 32'(id_illegal_o), 32'(m_ill));
`ifdef ID_PERF_CNT_EN
    chk("stall_cnt", stall_cnt_o, 32'(m_stall));
    chk("flush_cnt", flush_cnt_o, 32'(m_flush));
`endif
    if (!rstn) begin
      m_held = 0; m_bub = 0; m_instr = 0; m_pc = 0; m_sel = 3'd5; m_ill = 0;
      m_stall = 0; m_flush = 0;
    end else if (rdr) begin
      if (m_held) m_flush += iv ? 2 : 1;
      m_held = 0; m_bub = 0;
    end else if (haz) begin
      m_bub = 1; m_stall++;
    end else if (iv && e_rdy) begin
      m_held = 1; m_bub = 0; m_instr = ins; m_pc = pc;
      m_sel = ref_sel(ins); m_ill = ref_ill(ins);
    end else if (e_vld && er) begin
      m_held = 0; m_bub = 0;
    end
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [4:0] ops [13] = '{5'b00000, 5'b00011, 5'b00100, 5'b00101, 5'b01000, 5'b01100, 5'b01101,
                             5'b11000, 5'b11001, 5'b11011, 5'b11100, 5'b00010, 5'b11111};
    logic [31:0] r;
    r        = $urandom;
    r[19:15] = 5'($urandom_range(0, 7));
    r[24:20] = 5'($urandom_range(0, 7));
    r[6:2]   = ops[$urandom_range(0, 12)];
    r[1:0]   = ($urandom_range(0, 9) == 0) ? 2'b01 : 2'b11;
    return r;
  endfunction

  localparam logic [31:0] ADD_X6 = {7'd0, 5'd7, 5'd5, 3'd0, 5'd6, 7'h33};
  localparam logic [31:0] JAL_X1 = {12'h000, 5'd5, 3'd0, 5'd1, 7'h6F};
  localparam logic [31:0] ADDI_A = {12'd1, 5'd0, 3'd0, 5'd1, 7'h13};
  localparam logic [31:0] ADDI_B = {12'd2, 5'd0, 3'd0, 5'd2, 7'h13};

  initial begin
    m_held = 0; m_bub = 0; m_instr = 0; m_pc = 0; m_sel = 3'd5; m_ill = 0;
    m_stall = 0; m_flush = 0;
    pc = 32'h1000; rstn = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    chk("rst_if_ready", 32'(if_ready_o), 32'd1);
    chk("rst_id_valid", 32'(id_valid_o), 32'd0);
    chk("rst_imm_sel", 32'(id_imm_sel_o), 32'd5);
    check_and_tick();
    rstn = 1'b1;

    // three back-to-back ADDI beats
    for (int i = 0; i < 3; i++) begin
      drive(1, {12'(i + 1), 5'd0, 3'd0, 5'd1, 7'h13}, 1, 0, 0, 0, 0);
      check_and_tick();
      chk("addi_sel", 32'(id_imm_sel_o), 32'd0);
    end
    drive(0, 0, 1, 0, 0, 0, 0); chk("addi_last_vld", 32'(id_valid_o), 32'd1); check_and_tick();

    // load-use on rs1 = x5
    drive(1, ADD_X6, 1, 0, 0, 0, 0); check_and_tick();
    drive(0, 0, 1, 1, 1, 5'd5, 0);
    chk("lu_bubble_vld", 32'(id_valid_o), 32'd0);
    chk("lu_bubble_rdy", 32'(if_ready_o), 32'd0);
    check_and_tick();
    drive(0, 0, 1, 1, 1, 5'd5, 0);
    chk("lu_hold_vld", 32'(id_valid_o), 32'd1);
`ifdef ID_PERF_CNT_EN
    chk("lu_stall_cnt", stall_cnt_o, 32'd1);
`endif
    check_and_tick();

    // same with ex_rd = x0: no bubble
    drive(1, ADD_X6, 1, 0, 0, 0, 0); check_and_tick();
    drive(0, 0, 1, 1, 1, 5'd0, 0); chk("x0_no_bubble", 32'(id_valid_o), 32'd1); check_and_tick();

    // JAL reads no register even though bits[19:15] = 5
    drive(1, JAL_X1, 1, 0, 0, 0, 0); check_and_tick();
    drive(0, 0, 1, 1, 1, 5'd5, 0);
    chk("jal_no_bubble", 32'(id_valid_o), 32'd1);
    chk("jal_sel", 32'(id_imm_sel_o), 32'd4);
    check_and_tick();

    // redirect while FULL with a concurrent IF beat
    drive(1, ADDI_A, 0, 0, 0, 0, 0); check_and_tick();
    drive(1, ADDI_B, 0, 0, 0, 0, 1);
    chk("redir_vld", 32'(id_valid_o), 32'd0);
    chk("redir_rdy", 32'(if_ready_o), 32'd1);
    check_and_tick();
    drive(0, 0, 1, 0, 0, 0, 0);
    chk("post_redir_vld", 32'(id_valid_o), 32'd0);
`ifdef ID_PERF_CNT_EN
    chk("redir_flush_cnt", flush_cnt_o, 32'd2);
`endif
    check_and_tick();

    // EX backpressure for 4 cycles, then transfer + capture together
    drive(1, ADDI_A, 0, 0, 0, 0, 0); check_and_tick();
    for (int i = 0; i < 4; i++) begin
      drive(1, ADDI_B, 0, 0, 0, 0, 0);
      chk("bp_instr", id_instr_o, ADDI_A);
      chk("bp_vld", 32'(id_valid_o), 32'd1);
      chk("bp_rdy", 32'(if_ready_o), 32'd0);
      check_and_tick();
    end
    drive(1, ADDI_B, 1, 0, 0, 0, 0); chk("bp_release_rdy", 32'(if_ready_o), 32'd1); check_and_tick();
    chk("bp_new_instr", id_instr_o, ADDI_B);

    // illegal classification
    drive(1, 32'h0000_0000, 1, 0, 0, 0, 0); check_and_tick();
    chk("ill_zero", 32'(id_illegal_o), 32'd1);
    drive(1, 32'h0000_0013, 1, 0, 0, 0, 0); check_and_tick();
    chk("ill_addi", 32'(id_illegal_o), 32'd0);

    // randomized traffic, including occasional mid-run resets
    for (int c = 0; c < 3000; c++) begin
      rstn = ($urandom_range(0, 199) != 0);
      drive($urandom_range(0, 3) != 0, rand_instr(), $urandom_range(0, 3) != 0,
            $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
            5'($urandom_range(0, 7)), $urandom_range(0, 11) == 0);
      check_and_tick();
    end
    rstn = 1'b1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/id_stage_ctrl.md
# id_stage_ctrl

Sequencer for the ID stage of the five-stage RV32I pipeline. Owns the IF/ID pipeline register and the valid/ready handshakes on both sides of it. Detects load-use hazards and inserts a one-cycle bubble. Flushes on branch/jump redirect from EX, and pre-classifies each captured instruction's immediate format so the immediate generator and decoder see a registered format select.

## Interface
- `XLEN`, 32: instruction and PC width.
- `CNT_WIDTH`, 32: width of the performance counters; only used when `ID_PERF_CNT_EN` is defined.

Ports:
- `clk`  in  1  pipeline clock; all state changes on the rising edge.
- `rst`  in  1  reset, synchronous, active-low.
- `if_valid`  in  1  IF presents an instruction.
- `if_instr`  in  XLEN  fetched instruction.
- `if_pc`  in  XLEN  PC of `if_instr`.
- `if_ready`  out  1  ID can accept this cycle (combinational).
- `id_valid`  out  1  ID presents an instruction to EX (combinational from state and hazard).
- `id_instr`  out  XLEN  registered instruction.
- `id_pc`  out  XLEN  registered PC.
- `id_imm_sel`  out  3  registered immediate format: I=0, S=1, B=2, U=3, J=4, NONE=5.
- `id_illegal`  out  1  registered flag. Set when `instr[1:0] != 2'b11` or when `opcode[6:2]` is not an RV32I major opcode.
- `ex_ready`  in  1  EX accepts the ID instruction.
- `ex_valid`  in  1  EX holds a valid instruction.
- `ex_load`  in  1  the EX instruction is a load.
- `ex_rd`  in  5  destination register of the EX instruction.
- `redirect`  in  1  taken branch or jump resolved in EX; the ID contents are wrong-path.
- `stall_cnt`  out  CNT_WIDTH  load-use bubble count (macro only).
- `flush_cnt`  out  CNT_WIDTH  discarded-instruction count (macro only).

## Operation
FSM states:
- EMPTY: no instruction held.
- FULL: instruction held, hazard check active.
- HOLD: instruction held after a bubble, hazard check masked.

Definitions:
- Transfer out: `id_valid & ex_ready`.
- Capture: `if_valid & if_ready`.

Hazard:
- Hazard = state FULL & `ex_valid` & `ex_load` & `ex_rd != 0` & (`ex_rd == rs1` when rs1 is used, or `ex_rd == rs2` when rs2 is used).
- rs1 is used by R, I, S and B formats; rs2 by R, S and B; U and J use neither.

Ready and valid:
- `if_ready` = EMPTY, or transfer out this cycle, or `redirect`.
- `id_valid` = (FULL & !hazard) | HOLD. Forced to 0 while `redirect` is high.

Transitions, in priority order:
1. `redirect` → EMPTY. A beat presented by IF in the same cycle is consumed and discarded.
2. FULL & hazard → HOLD; no transfer out.
3. HOLD & !`ex_ready` → HOLD.
4. Capture → FULL, loading `id_instr`/`id_pc`/`id_imm_sel`/`id_illegal`. Applies whether the register was EMPTY or is being vacated by a transfer out this cycle.
5. Transfer out without capture → EMPTY.
6. Otherwise hold the current state and registers.

`id_imm_sel` is decoded from `if_instr[6:2]`:
- STORE → S; BRANCH → B; LUI/AUIPC → U; JAL → J; OP → NONE.
- All other opcodes → I.

## Timing
- Reset values: state EMPTY; `id_instr`, `id_pc` = 0; `id_imm_sel` = NONE; `id_illegal` = 0; counters = 0. Therefore `if_ready` = 1 and `id_valid` = 0 during and after reset.
- Reset asserted mid-stall or mid-transfer discards all held state on the next edge.
- Latency: beat captured at edge N appears on `id_*` after edge N; `id_valid` is high in cycle N+1 absent hazard or redirect.
- Throughput: one instruction per cycle when `ex_ready` is held high.
- Load-use: exactly one bubble cycle (`id_valid` = 0) per dependent instruction. The following cycle is HOLD with `id_valid` = 1.
- Hazard and redirect in the same cycle: redirect wins, and the stall is not counted.
- Stalls: `ex_ready` low holds `id_instr` stable and keeps `id_valid` asserted.

## Configuration
- `ID_PERF_CNT_EN` defined:
  - `stall_cnt` and `flush_cnt` ports and registers exist.
  - `stall_cnt` += 1 each FULL→HOLD transition.
  - `flush_cnt` += 1 on each `redirect` cycle with state != EMPTY. It adds a further 1 if a beat is also discarded that cycle.
  - Both counters saturate at all-ones.
- Undefined: no counter ports or logic.

## Structure
- Shared package/header (`riscv_def.v`):
  - state encodings;
  - `id_imm_sel` codes (`IMM_SEL_I` … `IMM_SEL_NONE`);
  - the existing `OP_*` opcode defines and `XLEN`.
- One natural sub-module, `imm_fmt_decode`: a combinational decode of opcode to imm_sel, rs1/rs2-used and illegal. It is shared with the decoder.

## Test plan
- Reset, then three back-to-back ADDI beats with `ex_ready` = 1 → `id_valid` high on cycles 1–3, `id_imm_sel` = 0, no bubbles.
- `ex_load` = 1, `ex_rd` = 5, ID holds `add x6,x5,x7` → one cycle with `id_valid` = 0, `if_ready` = 0, then `id_valid` = 1 (HOLD). With the macro, `stall_cnt` = 1. Repeat with `ex_rd` = 0 → no bubble.
- ID holds a JAL, `ex_load` = 1, `ex_rd` = 5 → no bubble (J uses no rs); `id_imm_sel` = 4.
- `redirect` asserted while FULL and `if_valid` = 1 → next cycle EMPTY, `id_valid` = 0, `flush_cnt` = 2.
- `ex_ready` low for 4 cycles with ID FULL → `id_instr` stable, `id_valid` high, `if_ready` low. Releasing `ex_ready` with `if_valid` high → transfer and capture in the same cycle.
- Beat `0x00000000` (low bits 00) → `id_illegal` = 1. Beat `0x00000013` → `id_illegal` = 0.
